// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcode
// and funct constants, ALU control codes, ALU op classes and mux selects.
// Used by the controller, its ALU decoder and the datapath ALU.
package mips_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUC_W  = 4;

  // Supported opcodes (instruction[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  // Supported R-type funct fields (instruction[5:0])
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  // ALU function select codes
  localparam logic [ALUC_W-1:0] ALUC_ADD = 4'b1010;
  localparam logic [ALUC_W-1:0] ALUC_SUB = 4'b1110;
  localparam logic [ALUC_W-1:0] ALUC_AND = 4'b0000;
  localparam logic [ALUC_W-1:0] ALUC_OR  = 4'b0001;
  localparam logic [ALUC_W-1:0] ALUC_NOR = 4'b0011;
  localparam logic [ALUC_W-1:0] ALUC_SLT = 4'b0101;

  // ALU source B select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Operation class handed from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_J_EX     = 4'd11,
    S_BNE_EX   = 4'd12
  } state_e;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps the FSM's operation class and the funct field to an ALU
// control code.
//   aluop       in   operation class (add / sub / decode funct)
//   funct       in   instruction[5:0]
//   alu_control out  ALU function select (combinational)
//   funct_ok    out  funct is a supported R-type function (1 outside funct mode)
module alu_decoder
  import mips_pkg::*;
(
  input  aluop_e              aluop,
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALUC_W-1:0]   alu_control,
  output logic                funct_ok
);

  always_comb begin
    alu_control = ALUC_ADD;
    funct_ok    = 1'b1;
    case (aluop)
      ALUOP_SUB:   alu_control = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALUC_ADD;
          FN_SUB:  alu_control = ALUC_SUB;
          FN_AND:  alu_control = ALUC_AND;
          FN_OR:   alu_control = ALUC_OR;
          FN_NOR:  alu_control = ALUC_NOR;
          FN_SLT:  alu_control = ALUC_SLT;
          default: funct_ok    = 1'b0;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback. Outputs decode from the state register (plus
// mem_ready in FETCH, zero for branches, opcode/funct for the illegal pulse).
// Build option: define BNE_SUPPORT_EN to execute bne; otherwise bne is illegal.
//   clk, reset           clock, asynchronous active-low reset
//   opcode, funct        instruction fields from the IR
//   zero, mem_ready      ALU zero flag, memory completion
//   alu_control, alu_src_a, alu_src_b, pc_src   datapath selects
//   pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
//   mem_to_reg           datapath strobes
//   illegal_op           one-cycle pulse on unsupported opcode/funct
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [ALUC_W-1:0]  alu_control,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal_op
);

  state_e state, state_nxt;
  aluop_e aluop;
  logic   funct_ok;
  logic   pc_write_c, branch_c;
  logic   mem_write_c, ir_write_c, reg_write_c, illegal_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct       (funct),
    .alu_control (alu_control),
    .funct_ok    (funct_ok)
  );

  // Next-state and output decode
  always_comb begin
    state_nxt   = S_FETCH;
    aluop       = ALUOP_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_B;
    pc_src      = PCSRC_ALU;
    pc_write_c  = 1'b0;
    branch_c    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    illegal_c   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_nxt  = S_DECODE;
        end else begin
          state_nxt  = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target computed speculatively while the opcode is decoded
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_RTYPE_EX;
          OP_BEQ:       state_nxt = S_BEQ_EX;
          OP_ADDI:      state_nxt = S_ADDI_EX;
          OP_J:         state_nxt = S_J_EX;
`ifdef BNE_SUPPORT_EN
          OP_BNE:       state_nxt = S_BNE_EX;
`endif
          default:      illegal_c = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord      = 1'b1;
        mem_read  = 1'b1;
        state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        mem_write_c = 1'b1;
        state_nxt   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_FUNCT;
        illegal_c = !funct_ok;
        state_nxt = funct_ok ? S_RTYPE_WB : S_FETCH;
      end
      S_RTYPE_WB: begin
        reg_write_c = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BEQ_EX: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch_c  = zero;
      end
`ifdef BNE_SUPPORT_EN
      S_BNE_EX: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch_c  = !zero;
      end
`endif
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = S_ADDI_WB;
      end
      S_ADDI_WB: reg_write_c = 1'b1;
      S_J_EX: begin
        pc_src     = PCSRC_JUMP;
        pc_write_c = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Write strobes are forced low while reset is held, independent of the clock
  assign pc_en      = reset & (pc_write_c | branch_c);
  assign ir_write   = reset & ir_write_c;
  assign mem_write  = reset & mem_write_c;
  assign reg_write  = reset & reg_write_c;
  assign illegal_op = reset & illegal_c;

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameters SHALL be: none; all encodings come from the shared package.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  6  instruction[31:26] from instruction register.
REQ-005 funct  in  6  instruction[5:0] from instruction register.
REQ-006 zero  in  1  ALU zero flag (result==0), combinational from ALU.
REQ-007 mem_ready  in  1  memory completes the current access this cycle.
REQ-008 alu_control  out  4  ALU function select: add 1010, sub 1110, and 0000, or 0001, nor 0011, slt 0101.
REQ-009 alu_src_a  out  1  0=PC, 1=register A.
REQ-010 alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-011 pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-012 pc_en  out  1  PC load enable = pc_write | (branch_taken).
REQ-013 iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg  out  1 each  standard datapath strobes.
REQ-014 illegal_op  out  1  one-cycle pulse on unsupported opcode/funct.

Function
REQ-015 Moore FSM; outputs SHALL decode combinationally from state register only (plus zero for pc_en).
REQ-016 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BEQ_EX, ADDI_EX, ADDI_WB, J_EX.
REQ-017 FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_control=add, pc_src=00; ir_write and pc_write asserted only in the cycle mem_ready=1; stay in FETCH while mem_ready=0.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_control=add; next state by opcode: 100011/101011->MEMADR, 000000->RTYPE_EX, 000100->BEQ_EX, 001000->ADDI_EX, 000010->J_EX, else FETCH with illegal_op=1.
REQ-019 MEMADR: alu_src_a=1, alu_src_b=10, add; ->MEMRD (lw) or MEMWR (sw).
REQ-020 MEMRD/MEMWR: iord=1, mem_read/mem_write=1; hold until mem_ready=1, then MEMRD->MEMWB, MEMWR->FETCH.
REQ-021 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; ->FETCH.
REQ-022 RTYPE_EX: alu_src_a=1, alu_src_b=00; funct 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt; unsupported funct -> FETCH with illegal_op=1, no writeback.
REQ-023 RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0; ->FETCH.
REQ-024 BEQ_EX: alu_src_a=1, alu_src_b=00, sub, pc_src=01; pc_en=zero; ->FETCH.
REQ-025 ADDI_EX add with alu_src_b=10 ->ADDI_WB; ADDI_WB reg_write=1, reg_dst=0, mem_to_reg=0 ->FETCH.
REQ-026 J_EX: pc_src=10, pc_en=1; ->FETCH.
REQ-027 Every strobe not listed for a state SHALL be 0; alu_control defaults to add.
REQ-028 Latencies with mem_ready=1: R-type/addi 4 cycles, lw 5, sw 4, beq/j 3.

Reset
REQ-029 reset low SHALL asynchronously force state=FETCH and force every write strobe (pc_en, ir_write, mem_write, reg_write) and illegal_op to 0 regardless of state.
REQ-030 reset asserted mid-instruction SHALL abandon it; after release first cycle is FETCH.

Configuration
REQ-031 Macro BNE_SUPPORT_EN: defined -> opcode 000101 routes DECODE->BNE_EX (as BEQ_EX but pc_en=~zero); undefined -> 000101 is illegal (illegal_op pulse, ->FETCH).

Structure
REQ-032 Package mips_pkg SHALL hold state enum, opcode/funct constants and the six alu_control codes, shared with the ALU.
REQ-033 Sub-module alu_decoder SHALL map (2-bit aluop, funct) -> alu_control combinationally; FSM supplies aluop.

Verification
REQ-034 add $3,$1,$2 (op 000000, funct 100000), mem_ready=1 -> states FETCH,DECODE,RTYPE_EX(alu_control=1010),RTYPE_WB(reg_write=1,reg_dst=1).
REQ-035 lw with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, mem_read=1 throughout, then MEMWB mem_to_reg=1.
REQ-036 beq, zero=1 -> pc_en=1 in BEQ_EX with alu_control=1110; zero=0 -> pc_en=0.
REQ-037 op 111111 -> illegal_op=1 for exactly one cycle in DECODE, next state FETCH, no writes.
REQ-038 reset low during MEMWR with mem_write=1 -> mem_write=0 immediately (no clock), FETCH after release.
REQ-039 bne, zero=0, with BNE_SUPPORT_EN -> pc_en=1; without it -> illegal_op=1.
